// File: rtl/dffsn_stim_checker.sv
// dffsn_stim_checker: LFSR stimulus driver and Q/QN response checker for set-low negedge flop cells
module dffsn_stim_checker #(
  parameter int          NUM_VECTORS = 256,
  parameter int          HALF        = 4,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          ERR_W       = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             Q_IN,
  input  logic             QN_IN,
  output logic             D_OUT,
  output logic             SN_OUT,
  output logic             CLKN_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [15:0]      VEC_CNT
);
  localparam int PW = $clog2(HALF);
  typedef enum logic [2:0] {IDLE, SET_A, SET_R, SETUP, FALL, RISE, END_V} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [15:0] lfsr_q, lfsr_d, lfsr_nx, vec_q, vec_d, vec_inc;
  logic [ERR_W-1:0] err_q, err_d;
  logic exp_q, exp_d, pass_q, pass_d, done_q, done_d, q_r, qn_r, last, cmp, mism;
  assign last    = ph_q == PW'(HALF - 1);
  assign lfsr_nx = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign vec_inc = vec_q + 16'd1;
  assign cmp     = last && (state_q == SET_A || state_q == FALL);
  assign exp_d   = cmp ? (state_q == SET_A ? 1'b1 : lfsr_q[0]) : exp_q;
  assign mism    = (q_r != exp_d) || (qn_r != ~exp_d);
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    vec_d   = vec_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    err_d   = (cmp && mism && err_q != '1) ? err_q + ERR_W'(1) : err_q;
    case (state_q)
      IDLE: if (START && !done_q) begin
        state_d = SET_A;
        lfsr_d  = SEED;
        vec_d   = '0;
        err_d   = '0;
        pass_d  = 1'b0;
      end
      SET_A: state_d = last ? SET_R : SET_A;
      SET_R: state_d = last ? END_V : SET_R;
      SETUP: state_d = last ? FALL : SETUP;
      FALL:  state_d = last ? RISE : FALL;
      RISE:  state_d = last ? END_V : RISE;
      END_V: begin
        vec_d  = vec_inc;
        lfsr_d = lfsr_nx;
        if (vec_inc == 16'(NUM_VECTORS)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          pass_d  = err_q == '0;
        end else begin
          state_d = (lfsr_nx[1] & lfsr_nx[2]) ? SET_A : SETUP;
        end
      end
      default: state_d = IDLE;
    endcase
    ph_d = (state_d != state_q || state_q == IDLE) ? '0 : ph_q + PW'(1);
  end
  always_ff @(posedge CLK) begin
    q_r  <= Q_IN;
    qn_r <= QN_IN;
    if (RST) begin
      state_q <= IDLE;
      ph_q    <= '0;
      lfsr_q  <= SEED;
      vec_q   <= '0;
      err_q   <= '0;
      exp_q   <= 1'b0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      lfsr_q  <= lfsr_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end
  // SN and CLKN each toggle only at their own state boundaries, so they never move together
  assign SN_OUT   = state_q != SET_A;
  assign CLKN_OUT = state_q != FALL;
  assign D_OUT    = (state_q == SETUP || state_q == FALL || state_q == RISE) ? lfsr_q[0] : 1'b0;
  assign BUSY     = state_q != IDLE;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign ERR_CNT  = err_q;
  assign VEC_CNT  = vec_q;
endmodule

// File: tb/tb_dffsn_stim_checker.sv
// tb_dffsn_stim_checker: three checker instances (16 vec, 16 vec ERR_W=2, 1000 vec) driving a behavioural dffsn flop
module tb_dffsn_stim_checker;
  localparam int H = 4;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst[3], start[3], d[3], sn[3], clkn[3], busy[3], done[3], pass[3], qin[3], qnin[3];
  logic [1:0] mode[3];
  logic [7:0] err[3];
  logic [15:0] vc[3];
  int pr[3], ns[3], sg[3];
  int n_cmp = 0, n_bad = 0;
  int bc, dn, e_busy, e_nset, e_sig, e_err0;
  logic s0;
  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int NV = (g == 2) ? 1000 : 16;
    localparam int W = (g == 1) ? 2 : 8;
    logic [W-1:0] e;
    logic fq = 1'b0, psn = 1'b1, pclk = 1'b1, pbusy = 1'b0;
    int slen = 0, clen = 0, prot = 0, nset = 0, sig = 0;
    always @(negedge clkn[g] or negedge sn[g]) fq <= !sn[g] ? 1'b1 : d[g];
    assign qin[g]  = mode[g] == 2'd0 ? fq : mode[g] == 2'd2;
    assign qnin[g] = mode[g] == 2'd0 ? ~fq : 1'b1;
    dffsn_stim_checker #(.NUM_VECTORS(NV), .HALF(H), .SEED(SEED), .ERR_W(W)) u (
      .CLK(clk), .RST(rst[g]), .START(start[g]), .Q_IN(qin[g]), .QN_IN(qnin[g]),
      .D_OUT(d[g]), .SN_OUT(sn[g]), .CLKN_OUT(clkn[g]), .BUSY(busy[g]), .DONE(done[g]),
      .PASS(pass[g]), .ERR_CNT(e), .VEC_CNT(vc[g]));
    assign err[g] = 8'(e);
    assign pr[g] = prot;
    assign ns[g] = nset;
    assign sg[g] = sig;
    always @(posedge clk) begin
      #2;
      if (busy[g] && !pbusy) begin
        prot = 0;
        nset = 0;
        sig = 0;
      end
      if (rst[g]) begin
        slen = 0;
        clen = 0;
      end else begin
        if (!sn[g] && !clkn[g]) prot++;
        if (sn[g] != psn && clkn[g] != pclk) prot++;
        if (!sn[g]) slen++;
        else begin
          if (slen != 0 && slen != H) prot++;
          slen = 0;
        end
        if (!clkn[g]) clen++;
        else begin
          if (clen != 0 && clen != H) prot++;
          clen = 0;
        end
        if (psn && !sn[g]) nset++;
        if (pclk && !clkn[g]) sig = sig * 3 + int'(d[g]);
      end
      psn = sn[g];
      pclk = clkn[g];
      pbusy = busy[g];
    end
  end
  function automatic void model(input int n, output int b, output int s, output int sig, output int e0);
    logic [15:0] l = SEED;
    logic set;
    b = 0; s = 0; sig = 0; e0 = 0;
    for (int v = 0; v < n; v++) begin
      if (v > 0) l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
      set = (v == 0) || (l[1] & l[2]);
      if (set) begin
        b += 2 * H + 1;
        s++;
        e0++;
      end else begin
        b += 3 * H + 1;
        sig = sig * 3 + int'(l[0]);
        if (l[0]) e0++;
      end
    end
  endfunction
  task automatic run_to_done(input int g, input int budget, input int poke, input bit poke_done);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    s0 = sn[g];
    bc = 0;
    dn = 0;
    for (int i = 0; i < budget && dn == 0; i++) begin
      start[g] = (i == poke);
      if (busy[g]) bc++;
      if (done[g]) begin
        dn++;
        if (poke_done) start[g] = 1'b1;
      end
      @(negedge clk);
    end
    start[g] = 1'b0;
    repeat (30) begin
      if (done[g]) dn++;
      if (busy[g]) bc++;
      @(negedge clk);
    end
  endtask
  task automatic test_reset();
    for (int g = 0; g < 3; g++) begin
      rst[g] = 1'b1; start[g] = 1'b0; mode[g] = 2'd0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) rst[g] = 1'b0;
    @(negedge clk);
    n_cmp++; if (clkn[0] !== 1'b1) begin n_bad++; $display("FAIL reset_clkn: got %b expected 1", clkn[0]); end
    n_cmp++; if (sn[0] !== 1'b1) begin n_bad++; $display("FAIL reset_sn: got %b expected 1", sn[0]); end
    n_cmp++; if (d[0] !== 1'b0) begin n_bad++; $display("FAIL reset_d: got %b expected 0", d[0]); end
    n_cmp++; if (busy[0] !== 1'b0 || done[0] !== 1'b0 || pass[0] !== 1'b0) begin n_bad++; $display("FAIL reset_flags: busy/done/pass %b%b%b expected 000", busy[0], done[0], pass[0]); end
    n_cmp++; if (err[0] !== 8'd0 || vc[0] !== 16'd0) begin n_bad++; $display("FAIL reset_counts: err %0d vec %0d expected 0 0", err[0], vc[0]); end
  endtask
  task automatic test_ideal();
    model(16, e_busy, e_nset, e_sig, e_err0);
    run_to_done(0, 400, -1, 1'b0);
    n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL ideal_done_count: got %0d expected 1", dn); end
    n_cmp++; if (s0 !== 1'b0) begin n_bad++; $display("FAIL ideal_vec0_set: sn %b expected 0", s0); end
    n_cmp++; if (busy[0] !== 1'b0 || pass[0] !== 1'b1) begin n_bad++; $display("FAIL ideal_busy_pass: busy %b pass %b expected 0 1", busy[0], pass[0]); end
    n_cmp++; if (err[0] !== 8'd0 || vc[0] !== 16'd16) begin n_bad++; $display("FAIL ideal_counts: err %0d vec %0d expected 0 16", err[0], vc[0]); end
    n_cmp++; if (bc !== e_busy) begin n_bad++; $display("FAIL ideal_latency: busy cycles %0d expected %0d", bc, e_busy); end
    n_cmp++; if (ns[0] !== e_nset || sg[0] !== e_sig) begin n_bad++; $display("FAIL ideal_pattern: sets %0d sig %0d expected %0d %0d", ns[0], sg[0], e_nset, e_sig); end
  endtask
  task automatic test_stuck0();
    mode[0] = 2'd1;
    model(16, e_busy, e_nset, e_sig, e_err0);
    run_to_done(0, 400, -1, 1'b0);
    n_cmp++; if (err[0] !== 8'(e_err0)) begin n_bad++; $display("FAIL stuck0_err: got %0d expected %0d", err[0], e_err0); end
    n_cmp++; if (pass[0] !== 1'b0 || dn !== 1) begin n_bad++; $display("FAIL stuck0_pass: pass %b dones %0d expected 0 1", pass[0], dn); end
    mode[0] = 2'd0;
  endtask
  task automatic test_saturate();
    mode[1] = 2'd2;
    run_to_done(1, 400, -1, 1'b0);
    n_cmp++; if (err[1] !== 8'd3) begin n_bad++; $display("FAIL sat_err: got %0d expected 3", err[1]); end
    n_cmp++; if (pass[1] !== 1'b0 || vc[1] !== 16'd16) begin n_bad++; $display("FAIL sat_pass_vec: pass %b vec %0d expected 0 16", pass[1], vc[1]); end
  endtask
  task automatic test_abort();
    int k;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    k = 0;
    while (!(vc[0] >= 16'd5 && clkn[0] == 1'b0) && k < 400) begin
      @(negedge clk);
      k++;
    end
    n_cmp++; if (k >= 400) begin n_bad++; $display("FAIL abort_reach_fall: waited %0d cycles expected < 400", k); end
    rst[0] = 1'b1;
    @(negedge clk);
    n_cmp++; if (clkn[0] !== 1'b1 || sn[0] !== 1'b1) begin n_bad++; $display("FAIL abort_pins: clkn %b sn %b expected 1 1", clkn[0], sn[0]); end
    n_cmp++; if (busy[0] !== 1'b0 || vc[0] !== 16'd0) begin n_bad++; $display("FAIL abort_state: busy %b vec %0d expected 0 0", busy[0], vc[0]); end
    rst[0] = 1'b0;
    dn = 0;
    repeat (30) begin
      if (done[0]) dn++;
      @(negedge clk);
    end
    n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses expected 0", dn); end
    model(16, e_busy, e_nset, e_sig, e_err0);
    run_to_done(0, 400, -1, 1'b0);
    n_cmp++; if (ns[0] !== e_nset || sg[0] !== e_sig || bc !== e_busy) begin n_bad++; $display("FAIL abort_rerun: sets %0d sig %0d busy %0d expected %0d %0d %0d", ns[0], sg[0], bc, e_nset, e_sig, e_busy); end
    n_cmp++; if (pass[0] !== 1'b1 || dn !== 1) begin n_bad++; $display("FAIL abort_rerun_pass: pass %b dones %0d expected 1 1", pass[0], dn); end
  endtask
  task automatic test_back_to_back();
    model(16, e_busy, e_nset, e_sig, e_err0);
    run_to_done(0, 400, 20, 1'b1);
    n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL b2b_done_count: got %0d expected 1", dn); end
    n_cmp++; if (bc !== e_busy) begin n_bad++; $display("FAIL b2b_busy: got %0d expected %0d", bc, e_busy); end
    n_cmp++; if (vc[0] !== 16'd16 || busy[0] !== 1'b0) begin n_bad++; $display("FAIL b2b_vec: vec %0d busy %b expected 16 0", vc[0], busy[0]); end
  endtask
  task automatic test_protocol();
    model(1000, e_busy, e_nset, e_sig, e_err0);
    run_to_done(2, 20000, -1, 1'b0);
    n_cmp++; if (pr[2] !== 0) begin n_bad++; $display("FAIL proto_violations: got %0d expected 0", pr[2]); end
    n_cmp++; if (s0 !== 1'b0) begin n_bad++; $display("FAIL proto_vec0_set: sn %b expected 0", s0); end
    n_cmp++; if (ns[2] !== e_nset || sg[2] !== e_sig) begin n_bad++; $display("FAIL proto_pattern: sets %0d sig %0d expected %0d %0d", ns[2], sg[2], e_nset, e_sig); end
    n_cmp++; if (vc[2] !== 16'd1000 || pass[2] !== 1'b1 || dn !== 1) begin n_bad++; $display("FAIL proto_end: vec %0d pass %b dones %0d expected 1000 1 1", vc[2], pass[2], dn); end
    n_cmp++; if (bc !== e_busy) begin n_bad++; $display("FAIL proto_latency: got %0d expected %0d", bc, e_busy); end
  endtask
  initial begin
    test_reset();
    test_ideal();
    test_stuck0();
    test_saturate();
    test_abort();
    test_back_to_back();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dffsn_stim_checker.md
Name: dffsn_stim_checker

Overview:
- Self-timed stimulus driver and response checker for the set-low, negative-edge-clocked flop cell family (D, SN, CLKN in; Q, QN out).
- It is the initiator side of that cell interface: it drives D, SN and CLKN from an LFSR pattern, models the expected Q, samples Q/QN and counts mismatches.
- Used in the library's silicon test structures and in the gate-level regression bench for the dffsn cells.

Parameters:
- NUM_VECTORS, 256, vectors per run; legal range 1..65535.
- HALF, 4, CLK cycles per stimulus phase; minimum 2.
- SEED, 16'hACE1, LFSR load value at START; must be nonzero.
- ERR_W, 8, ERR_CNT width; the count saturates at all-ones.

Ports:
- CLK  input  1  block clock; every register updates on posedge CLK.
- RST  input  1  reset, synchronous and active-high.
- START  input  1  single-cycle pulse that begins a run; ignored while BUSY=1.
- Q_IN  input  1  DUT Q.
- QN_IN  input  1  DUT QN.
- D_OUT  output  1  drives DUT D.
- SN_OUT  output  1  drives DUT SN (active-low set).
- CLKN_OUT  output  1  drives DUT CLKN; DUT captures on its falling edge.
- BUSY  output  1  high while a run is in progress.
- DONE  output  1  one-cycle pulse at the end of a run.
- PASS  output  1  1 if ERR_CNT==0 at the end of the run; holds until the next START or RST.
- ERR_CNT  output  ERR_W  saturating mismatch count.
- VEC_CNT  output  16  number of vectors completed in the current run.

Behaviour:
- Reset (RST=1 at posedge CLK):
  - state=IDLE, CLKN_OUT=1, SN_OUT=1, D_OUT=0.
  - BUSY=0, DONE=0, PASS=0, ERR_CNT=0, VEC_CNT=0, exp_q=0, lfsr=SEED, phase counter=0.
  - RST mid-run aborts immediately; no DONE pulse.
- Q_IN and QN_IN are registered once (q_r, qn_r). Compares always use the registered values.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances once at the end of each vector.
  - D bit = lfsr[0].
  - set_vec = lfsr[1] & lfsr[2].
  - Vector 0 of every run is forced to be a set vector, so the DUT starts from a known state.
- Each state lasts exactly HALF CLK cycles. A compare happens on the last cycle of the state.
- IDLE: outputs hold at their reset values (except PASS and ERR_CNT, which hold). On START:
  - ERR_CNT cleared, VEC_CNT cleared, PASS cleared, lfsr=SEED, BUSY=1.
  - Next state is SET_A if the vector is a set vector, otherwise SETUP.
- SET_A: SN_OUT=0, CLKN_OUT=1. Last cycle: exp_q←1, then compare. Next state SET_R.
- SET_R: SN_OUT=1, CLKN_OUT=1. Next state END_V.
- SETUP: CLKN_OUT=1, D_OUT=lfsr[0]. Next state FALL.
- FALL: CLKN_OUT=0, D_OUT held. Last cycle: exp_q←D_OUT, then compare. Next state RISE.
- RISE: CLKN_OUT=1. Next state END_V.
- END_V (1 cycle): VEC_CNT+1, lfsr advance.
  - If VEC_CNT+1==NUM_VECTORS: go to IDLE, BUSY=0, DONE=1 for one cycle, PASS=(ERR_CNT==0) including any error from this vector.
  - Else go to SET_A or SETUP according to the new set_vec.
- Compare: a mismatch is (q_r != exp_q) OR (qn_r != ~exp_q). Each mismatch adds 1 to ERR_CNT; at most 1 per compare; saturates at 2^ERR_W−1.
- SN_OUT is never low while CLKN_OUT is low. CLKN_OUT and SN_OUT never change in the same cycle.
- Vector latency: normal vector = 3*HALF+1 cycles; set vector = 2*HALF+1 cycles.
- START asserted in the same cycle as DONE is ignored. It is accepted from the next cycle on.

Test Plan:
- Ideal flop model attached, NUM_VECTORS=16, HALF=4, START pulse -> DONE exactly once, BUSY low after DONE, PASS=1, ERR_CNT=0, VEC_CNT=16.
- DUT Q stuck at 0 with QN=~Q -> every set vector and every D=1 vector mismatches. ERR_CNT equals that count as computed by the reference LFSR model; PASS=0.
- ERR_W=2 with DUT Q stuck at 1 and QN stuck at 1 -> ERR_CNT saturates at 3 and does not wrap; PASS=0.
- RST raised in FALL of vector 5 -> next cycle CLKN_OUT=1, SN_OUT=1, BUSY=0, VEC_CNT=0; no DONE pulse. A new START re-runs with the identical pattern from SEED.
- START pulsed while BUSY, and again in the DONE cycle -> both ignored; a single DONE pulse, VEC_CNT=NUM_VECTORS.
- Protocol monitor over a 1000-vector run -> SN_OUT=0 only while CLKN_OUT=1. Every SN_OUT low pulse and every CLKN_OUT phase lasts exactly HALF cycles. Vector 0 is a set vector.
